// File: rtl/flop_bank_arbiter.sv
// flop_bank_arbiter: round-robin write sequencer sharing one WIDTH-bit register among NUM_REQ requesters.
// Define FLOP_ARB_REQ0_PRIORITY_EN to give requester 0 absolute priority.
module flop_bank_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 8,
  parameter int HOLD_CYCLES = 2,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]       ack,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid,
  output logic [IW-1:0]            owner,
  output logic                     busy
);
  localparam int CW = HOLD_CYCLES > 0 ? $clog2(HOLD_CYCLES + 1) : 1;
  typedef enum logic {IDLE, HOLD} state_t;
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_ptr, r_owner;
  logic [NUM_REQ-1:0] r_ack;
  logic [WIDTH-1:0] r_q;
  logic r_valid;
  logic [NUM_REQ-1:0] w_eff, w_rot, w_oh;
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [IW-1:0] w_g, w_nxt;
  logic [WIDTH-1:0] w_d;
  logic w_hit;
  int w_off, w_sum;
  always_comb begin
    // masking the requester being acked stops a held req from being served twice
    w_eff = req & ~r_ack;
    w_hit = |w_eff;
    w_dbl = {w_eff, w_eff} >> r_ptr;
    w_rot = w_dbl[NUM_REQ-1:0];
    w_off = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (w_rot[i]) w_off = i;
    w_sum = int'(r_ptr) + w_off;
    w_g = IW'(w_sum >= NUM_REQ ? w_sum - NUM_REQ : w_sum);
`ifdef FLOP_ARB_REQ0_PRIORITY_EN
    if (w_eff[0]) w_g = '0;
`endif
    w_nxt = (w_g == IW'(NUM_REQ - 1)) ? '0 : w_g + 1'b1;
    w_oh = NUM_REQ'(1) << w_g;
    w_d = '0;
    for (int i = 0; i < NUM_REQ; i++) if (w_g == IW'(i)) w_d = wdata[i*WIDTH +: WIDTH];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_ptr <= '0;
      r_owner <= '0;
      r_ack <= '0;
      r_q <= '0;
      r_valid <= 1'b0;
    end else if (r_state == HOLD) begin
      r_ack <= '0;
      if (r_cnt == CW'(1)) r_state <= IDLE;
      else r_cnt <= r_cnt - CW'(1);
    end else if (w_hit) begin
      r_q <= w_d;
      r_valid <= 1'b1;
      r_owner <= w_g;
      r_ack <= w_oh;
`ifdef FLOP_ARB_REQ0_PRIORITY_EN
      if (!w_eff[0]) r_ptr <= w_nxt;
`else
      r_ptr <= w_nxt;
`endif
      if (HOLD_CYCLES > 0) begin
        r_state <= HOLD;
        r_cnt <= CW'(HOLD_CYCLES);
      end
    end else r_ack <= '0;
  end
  assign ack = r_ack;
  assign q = r_q;
  assign q_valid = r_valid;
  assign owner = r_owner;
  assign busy = (r_state == HOLD);
endmodule

// File: tb/tb_flop_bank_arbiter.sv
// tb_flop_bank_arbiter: table-driven scoreboard bench for flop_bank_arbiter (HOLD_CYCLES=2 and 0 instances).
module tb_flop_bank_arbiter;
  localparam int N = 4;
  localparam int W = 8;
`ifdef FLOP_ARB_REQ0_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  localparam logic [N*W-1:0] D0 = {8'h13, 8'h12, 8'h11, 8'h10};
  localparam logic [N*W-1:0] D1 = {8'h13, 8'h12, 8'hFE, 8'h10};
  typedef struct {
    logic [N-1:0] req;
    logic [N*W-1:0] wdata;
    logic [N-1:0] ack;
    logic [W-1:0] q;
    logic [1:0] owner;
    logic busy;
    logic valid;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] req, req1, ack, ack1;
  logic [N*W-1:0] wdata, wdata1;
  logic [W-1:0] q, q1;
  logic q_valid, q_valid1, busy, busy1;
  logic [1:0] owner, owner1;
  int n_pass = 0;
  int n_tot = 0;
  vec_t tbl[23];
  vec_t sb[$];
  vec_t e;
  always #5 clk = ~clk;
  flop_bank_arbiter #(.NUM_REQ(N), .WIDTH(W), .HOLD_CYCLES(2)) u0 (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata), .ack(ack),
    .q(q), .q_valid(q_valid), .owner(owner), .busy(busy));
  flop_bank_arbiter #(.NUM_REQ(N), .WIDTH(W), .HOLD_CYCLES(0)) u1 (
    .clk(clk), .reset(reset), .req(req1), .wdata(wdata1), .ack(ack1),
    .q(q1), .q_valid(q_valid1), .owner(owner1), .busy(busy1));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic vec_t mk(logic [3:0] r, logic [31:0] d, logic [3:0] a, logic [7:0] qq,
                              logic [1:0] o, logic b, logic v);
    vec_t t;
    t.req = r; t.wdata = d; t.ack = a; t.q = qq; t.owner = o; t.busy = b; t.valid = v;
    return t;
  endfunction
  initial begin
    // all requesters held high: grant every third edge, rotating 0..3 (always 0 with priority)
    for (int k = 0; k < 13; k++) begin
      int g;
      g = PRIO ? 0 : (k / 3) % 4;
      tbl[k] = mk(4'hF, D0, (k % 3 == 0) ? 4'(1 << g) : 4'h0, 8'(8'h10 + g), 2'(g), k % 3 != 2, 1'b1);
    end
    tbl[13] = mk(4'b0010, D1, 4'h0, 8'h10, 2'd0, 1'b1, 1'b1);
    tbl[14] = mk(4'b0010, D1, 4'h0, 8'h10, 2'd0, 1'b0, 1'b1);
    tbl[15] = mk(4'b0010, D1, 4'b0010, 8'hFE, 2'd1, 1'b1, 1'b1);
    tbl[16] = mk(4'b0000, D1, 4'h0, 8'hFE, 2'd1, 1'b1, 1'b1);
    tbl[17] = mk(4'b0000, D1, 4'h0, 8'hFE, 2'd1, 1'b0, 1'b1);
    tbl[18] = mk(4'b0000, D1, 4'h0, 8'hFE, 2'd1, 1'b0, 1'b1);
    if (PRIO) begin
      tbl[19] = mk(4'b0101, D1, 4'b0001, 8'h10, 2'd0, 1'b1, 1'b1);
      tbl[20] = mk(4'b0110, D1, 4'h0, 8'h10, 2'd0, 1'b1, 1'b1);
      tbl[21] = mk(4'b0110, D1, 4'h0, 8'h10, 2'd0, 1'b0, 1'b1);
      tbl[22] = mk(4'b0110, D1, 4'b0100, 8'h12, 2'd2, 1'b1, 1'b1);
    end else begin
      tbl[19] = mk(4'b0101, D1, 4'b0100, 8'h12, 2'd2, 1'b1, 1'b1);
      tbl[20] = mk(4'b0001, D1, 4'h0, 8'h12, 2'd2, 1'b1, 1'b1);
      tbl[21] = mk(4'b0001, D1, 4'h0, 8'h12, 2'd2, 1'b0, 1'b1);
      tbl[22] = mk(4'b0001, D1, 4'b0001, 8'h10, 2'd0, 1'b1, 1'b1);
    end
    reset = 1'b1; req = 4'hF; wdata = D0; req1 = '0; wdata1 = '0;
    #2 reset = 1'b0;
    step; step;
    chk("rst_q", q, 8'h00);
    chk("rst_valid", q_valid, 1'b0);
    chk("rst_ack", ack, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", owner, 2'd0);
    chk("rst_q1", q1, 8'h00);
    reset = 1'b1;
    for (int i = 0; i < 23; i++) begin
      req = tbl[i].req;
      wdata = tbl[i].wdata;
      sb.push_back(tbl[i]);
      step;
      e = sb.pop_front();
      chk($sformatf("row%0d_ack", i), ack, e.ack);
      chk($sformatf("row%0d_q", i), q, e.q);
      chk($sformatf("row%0d_owner", i), owner, e.owner);
      chk($sformatf("row%0d_busy", i), busy, e.busy);
      chk($sformatf("row%0d_valid", i), q_valid, e.valid);
    end
    // reset landing in the first HOLD cycle clears everything at once
    req = 4'b1000; wdata = {8'hA5, 8'h12, 8'hFE, 8'h10};
    step; step; step;
    chk("mh_grant_ack", ack, 4'b1000);
    chk("mh_grant_q", q, 8'hA5);
    chk("mh_grant_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("mh_busy", busy, 1'b0);
    chk("mh_q", q, 8'h00);
    chk("mh_valid", q_valid, 1'b0);
    chk("mh_ack", ack, 4'h0);
    chk("mh_owner", owner, 2'd0);
    step;
    reset = 1'b1;
    step;
    chk("mh_regrant_ack", ack, 4'b1000);
    chk("mh_regrant_q", q, 8'hA5);
    chk("mh_regrant_owner", owner, 2'd3);
    chk("mh_regrant_valid", q_valid, 1'b1);
    req = '0;
    // zero-hold instance: held req is not served twice, re-raise is a new request
    req1 = 4'b0100; wdata1 = {8'h44, 8'h5A, 8'h22, 8'h11};
    step;
    chk("b2b_ack_a", ack1, 4'b0100);
    chk("b2b_q_a", q1, 8'h5A);
    chk("b2b_busy", busy1, 1'b0);
    chk("b2b_owner", owner1, 2'd2);
    step;
    chk("b2b_no_double", ack1, 4'h0);
    req1 = '0;
    step;
    chk("b2b_idle", ack1, 4'h0);
    wdata1 = {8'h44, 8'h77, 8'h22, 8'h11}; req1 = 4'b0100;
    step;
    chk("b2b_reraise_ack", ack1, 4'b0100);
    chk("b2b_reraise_q", q1, 8'h77);
    req1 = 4'b0011;
    step;
    chk("b2b_g0_ack", ack1, 4'b0001);
    chk("b2b_g0_q", q1, 8'h11);
    step;
    chk("b2b_g1_ack", ack1, 4'b0010);
    chk("b2b_g1_q", q1, 8'h22);
    step;
    chk("b2b_g0b_ack", ack1, 4'b0001);
    req1 = '0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/flop_bank_arbiter.md
Name: flop_bank_arbiter

Overview:
- Shares a single WIDTH-bit storage register among NUM_REQ requesters.
- Round-robin arbitration picks one requester per grant. The winner's data is captured into the register and the winner gets a one-cycle acknowledge.
- An optional guard interval (HOLD) keeps the register stable between successive writes.
- Sits in front of the team's flip-flop bank as its write sequencer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, data width of the shared register.
- HOLD_CYCLES, 2, guard cycles after each write during which no new grant is issued (0 = back-to-back writes allowed).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- req  input  NUM_REQ  per-requester write request, level-sensitive.
- wdata  input  NUM_REQ*WIDTH  packed write data; requester i occupies bits [i*WIDTH +: WIDTH].
- ack  output  NUM_REQ  one-hot, one-cycle pulse to the requester just written.
- q  output  WIDTH  shared register contents.
- q_valid  output  1  high once any write has occurred since reset.
- owner  output  $clog2(NUM_REQ)  index of the last requester written.
- busy  output  1  high while in HOLD.

Behaviour:
- Reset (reset=0, asynchronous): q=0, q_valid=0, owner=0, ack=0, busy=0, round-robin pointer ptr=0, hold counter=0, state=IDLE.
- Reset asserted mid-HOLD aborts the hold immediately; no pending ack survives reset.
- States are IDLE and HOLD.
- IDLE, at a rising edge:
  - Effective request eff = req & ~ack. The requester being acked this cycle is masked, so a held req is never double-served.
  - If eff==0: nothing changes; ack goes to 0.
  - If eff!=0: winner g = first set bit of eff searching circularly from ptr upward.
  - On that edge: q<=wdata[g], q_valid<=1, owner<=g, ack<=one-hot(g), ptr<=(g+1) mod NUM_REQ.
  - Next state: HOLD if HOLD_CYCLES>0 (counter loaded with HOLD_CYCLES); otherwise stays IDLE.
- Latency: req sampled at edge k gives q/ack valid in cycle k..k+1 (one edge). ack is high for exactly one cycle.
- HOLD:
  - busy=1 and ack=0 after the first HOLD cycle.
  - req is ignored and q is held.
  - The counter decrements each edge; the state returns to IDLE on the edge where the counter reaches 1.
  - HOLD therefore lasts exactly HOLD_CYCLES cycles. The earliest next grant edge is k+HOLD_CYCLES+1.
- Requester protocol: keep req and wdata stable until ack is seen, then drop req by the end of the ack cycle. A req still high after that is treated as a new request.
- Wrap-around: ptr wraps from NUM_REQ-1 to 0. With all req high, grants go 0,1,2,3,0,… .
- Simultaneous events: only one grant per arbitration edge. A request arriving during HOLD waits; it is not lost as long as it is held.
- busy is decoded from the registered state; it never glitches combinationally from req.

Optional Feature:
- Macro: FLOP_ARB_REQ0_PRIORITY_EN.
- Defined: requester 0 has absolute priority. If eff[0]=1 in IDLE, g=0 regardless of ptr, and ptr is not updated on a requester-0 grant. Other requesters are still served round-robin among themselves.
- Undefined: pure round-robin as described, with no special requester.

Test Plan:
1. Reset check: hold reset=0 for 2 cycles with req=4'b1111 -> q=8'h00, q_valid=0, ack=0, busy=0. Release reset -> first grant to requester 0.
2. Single write: wdata[1]=8'hFE, req=4'b0010 at edge k -> q=8'hFE, owner=1, ack=4'b0010 for one cycle, busy=1 for exactly 2 cycles (HOLD_CYCLES=2).
3. Round-robin fairness: req=4'b1111 held, data i = 8'h10+i -> q sequence 8'h10,8'h11,8'h12,8'h13,8'h10, with grants spaced 3 cycles apart.
4. Back-to-back (HOLD_CYCLES=0): req[2] held high through its ack cycle -> no second ack to requester 2 on the next edge; second grant only after req is re-raised.
5. Mid-hold reset: assert reset=0 one cycle into HOLD -> busy=0, q=8'h00, q_valid=0 immediately. After release, the pending req[3] is granted on the first edge.
6. With FLOP_ARB_REQ0_PRIORITY_EN defined, ptr=2, req=4'b0101 -> requester 0 granted first, then requester 2; ptr stays 2 after the requester-0 grant.
